// File: rtl/pet_ram_pkg.sv
// Shared types for the DDR byte-port arbiter: FSM states, access owner and
// the data returned to the tape player when a read is aborted.
package pet_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_LD,
        OWN_TP
    } owner_t;

    localparam logic [7:0] TP_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/ram_arbiter_if.sv
// Loader, tape-player and memory back-end signals of the DDR byte-port arbiter.
// The arbiter uses the slave modport; the environment uses master.
interface ram_arbiter_if #(
    parameter int unsigned AW = 25,
    parameter int unsigned DW = 8
);

    logic          ld_active;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_din;
    logic          ld_wait;

    logic          tp_rd;
    logic [AW-1:0] tp_addr;
    logic [DW-1:0] tp_dout;
    logic          tp_valid;
    logic          cpu_stall;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic          mem_rd;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;

    modport slave (
        input  ld_active, ld_wr, ld_addr, ld_din, tp_rd, tp_addr, mem_dout, mem_ready,
        output ld_wait, tp_dout, tp_valid, cpu_stall, mem_addr, mem_din, mem_we, mem_rd
    );

    modport master (
        output ld_active, ld_wr, ld_addr, ld_din, tp_rd, tp_addr, mem_dout, mem_ready,
        input  ld_wait, tp_dout, tp_valid, cpu_stall, mem_addr, mem_din, mem_we, mem_rd
    );

endinterface

// File: rtl/ram_arb_req.sv
// Single-entry request latch: pending flag plus payload, last strobe wins.
// A strobe coinciding with the grant keeps the flag set so it is not lost.
module ram_arb_req #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_i,
    input  logic          clr_i,
    input  logic [PW-1:0] payload_i,
    output logic          pend_o,
    output logic [PW-1:0] payload_o
);

    logic          pend_q;
    logic [PW-1:0] payload_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            payload_q <= '0;
        end else if (set_i) begin
            pend_q    <= 1'b1;
            payload_q <= payload_i;
        end else if (clr_i) begin
            pend_q    <= 1'b0;
        end
    end

    assign pend_o    = pend_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the DDR byte port between the ROM/TAP loader (writes) and the tape
// player (reads). Optional watchdog on WAIT: define RAM_ARB_WATCHDOG_EN.
module ram_arbiter
    import pet_ram_pkg::*;
#(
    parameter int unsigned AW = 25,
    parameter int unsigned DW = 8
`ifdef RAM_ARB_WATCHDOG_EN
   ,parameter int unsigned TIMEOUT = 4096
`endif
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
`ifdef RAM_ARB_WATCHDOG_EN
   ,output logic         err
`endif
);

    logic             ld_pend, tp_pend, ld_grant, tp_grant, tp_set;
    logic [AW+DW-1:0] ld_payload;
    logic [AW-1:0]    tp_payload;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic          seen_low_q, seen_low_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic [DW-1:0] tp_dout_q, tp_dout_d;
    logic          tp_valid_q, tp_valid_d;
`ifdef RAM_ARB_WATCHDOG_EN
    logic [12:0]   wd_cnt_q, wd_cnt_d;
    logic          err_q, err_d;
`endif

    // Tape reads are ignored while a download owns the memory.
    assign tp_set = bus.tp_rd & ~bus.ld_active;

    ram_arb_req #(.PW(AW + DW)) u_ld_req (
        .clk       (clk),
        .reset     (reset),
        .set_i     (bus.ld_wr),
        .clr_i     (ld_grant),
        .payload_i ({bus.ld_addr, bus.ld_din}),
        .pend_o    (ld_pend),
        .payload_o (ld_payload)
    );

    ram_arb_req #(.PW(AW)) u_tp_req (
        .clk       (clk),
        .reset     (reset),
        .set_i     (tp_set),
        .clr_i     (tp_grant),
        .payload_i (bus.tp_addr),
        .pend_o    (tp_pend),
        .payload_o (tp_payload)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_LD;
            seen_low_q <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            tp_dout_q  <= '0;
            tp_valid_q <= 1'b0;
`ifdef RAM_ARB_WATCHDOG_EN
            wd_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            seen_low_q <= seen_low_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            tp_dout_q  <= tp_dout_d;
            tp_valid_q <= tp_valid_d;
`ifdef RAM_ARB_WATCHDOG_EN
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        seen_low_d = seen_low_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        tp_dout_d  = tp_dout_q;
        tp_valid_d = 1'b0;
        ld_grant   = 1'b0;
        tp_grant   = 1'b0;
`ifdef RAM_ARB_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mem_ready && (ld_pend || tp_pend)) begin
                    state_d = ISSUE;
                    if (ld_pend) begin
                        owner_d                = OWN_LD;
                        ld_grant               = 1'b1;
                        {mem_addr_d, mem_din_d} = ld_payload;
                    end else begin
                        owner_d    = OWN_TP;
                        tp_grant   = 1'b1;
                        mem_addr_d = tp_payload;
                    end
                end
            end
            ISSUE: begin
                seen_low_d = 1'b0;
                state_d    = WAIT;
`ifdef RAM_ARB_WATCHDOG_EN
                wd_cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (!bus.mem_ready) seen_low_d = 1'b1;
                // Completion needs a low-then-high on mem_ready, not just a high level.
                if (bus.mem_ready && seen_low_q) begin
                    state_d = IDLE;
                    if (owner_q == OWN_TP) begin
                        tp_dout_d  = bus.mem_dout;
                        tp_valid_d = 1'b1;
                    end
                end
`ifdef RAM_ARB_WATCHDOG_EN
                else if (wd_cnt_q == 13'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_TP) begin
                        tp_dout_d  = DW'(TP_TIMEOUT_DATA);
                        tp_valid_d = 1'b1;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + 13'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ld_wait   = ld_pend | bus.ld_wr | ((owner_q == OWN_LD) && (state_q != IDLE));
    assign bus.cpu_stall = tp_pend | tp_set | ((owner_q == OWN_TP) && (state_q != IDLE));
    assign bus.mem_we    = (state_q == ISSUE) && (owner_q == OWN_LD);
    assign bus.mem_rd    = (state_q == ISSUE) && (owner_q == OWN_TP);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.tp_dout   = tp_dout_q;
    assign bus.tp_valid  = tp_valid_q;
`ifdef RAM_ARB_WATCHDOG_EN
    assign err           = err_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a
// request/backend model. Define RAM_ARB_WATCHDOG_EN to cover the watchdog.
module tb_ram_arbiter;

    localparam int AW = 25;
    localparam int DW = 8;
`ifdef RAM_ARB_WATCHDOG_EN
    localparam int WD_TIMEOUT = 16;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef RAM_ARB_WATCHDOG_EN
    logic err;
    ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(WD_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .err(err));
`else
    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] mem [logic [AW-1:0]];

    // Outstanding requests as seen from the requesters
    bit            ld_out, ld_iss, tp_out, tp_iss;
    logic [AW-1:0] ld_a, tp_a;
    logic [7:0]    ld_d;
    int            ld_t, tp_t;

    // Behavioural back end
    bit         be_busy, be_done, be_tp, hold_low;
    int         be_low, be_lat, be_start;
    logic [7:0] be_data;

    bit         tv_now, tv_next, exp_err;
    logic [7:0] td_exp, td_next;
    int         we_cnt, rd_cnt, tv_cnt, last_we, last_rd;

    bit            nx_ld_wr, nx_tp_rd, nx_ld_active;
    logic [AW-1:0] nx_ld_addr, nx_tp_addr;
    logic [7:0]    nx_ld_din;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rd_mem(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        tv_now  = tv_next;
        tv_next = 1'b0;
        if (tv_now) td_exp = td_next;
        be_done = 1'b0;
        if (be_busy && (be_low > 0 || hold_low)) begin
            bus.mem_ready = 1'b0;
            if (be_low > 0) be_low--;
        end else begin
            bus.mem_ready = 1'b1;
            be_done = be_busy;
        end
        bus.mem_dout  = be_data;
        bus.ld_active = nx_ld_active;
        bus.ld_wr     = nx_ld_wr;
        bus.ld_addr   = nx_ld_addr;
        bus.ld_din    = nx_ld_din;
        bus.tp_rd     = nx_tp_rd;
        bus.tp_addr   = nx_tp_addr;
        if (nx_ld_wr) begin
            ld_out = 1; ld_iss = 0; ld_a = nx_ld_addr; ld_d = nx_ld_din; ld_t = cyc;
        end
        if (nx_tp_rd && !nx_ld_active) begin
            tp_out = 1; tp_iss = 0; tp_a = nx_tp_addr; tp_t = cyc;
        end
        nx_ld_wr = 0;
        nx_tp_rd = 0;

        @(negedge clk);
        check("ld_wait", bus.ld_wait, ld_out);
        check("cpu_stall", bus.cpu_stall, tp_out);
        check("tp_valid", bus.tp_valid, tv_now);
        check("tp_dout", bus.tp_dout, td_exp);
`ifdef RAM_ARB_WATCHDOG_EN
        check("err", err, exp_err);
`endif
        if (bus.tp_valid) tv_cnt++;
        if (bus.mem_we || bus.mem_rd) begin
            check("strobe_busy", {bus.mem_we & bus.mem_rd, be_busy}, 0);
            if (bus.mem_we) begin
                we_cnt++; last_we = cyc;
                check("we_req", ld_out & ~ld_iss, 1);
                check("we_addr", bus.mem_addr, ld_a);
                check("we_din", bus.mem_din, ld_d);
                mem[ld_a] = ld_d;
                ld_iss = 1; be_tp = 0;
            end else begin
                rd_cnt++; last_rd = cyc;
                check("rd_req", tp_out & ~tp_iss, 1);
                check("rd_addr", bus.mem_addr, tp_a);
                // A loader request latched before the grant cycle must win
                check("rd_prio", ld_out && !ld_iss && (ld_t <= cyc - 2), 0);
                tp_iss = 1; be_tp = 1;
                be_data = rd_mem(tp_a);
            end
            be_busy  = 1;
            be_start = cyc;
            be_low   = (be_lat > 0) ? be_lat : int'($urandom_range(1, 3));
        end
        if (be_done) begin
            be_busy = 0;
            if (be_tp) begin tp_out = 0; tv_next = 1; td_next = be_data; end
            else ld_out = 0;
        end
`ifdef RAM_ARB_WATCHDOG_EN
        else if (be_busy && (cyc - be_start == WD_TIMEOUT)) begin
            be_busy = 0; hold_low = 0; be_low = 0; exp_err = 1;
            if (be_tp) begin tp_out = 0; tv_next = 1; td_next = 8'hFF; end
            else ld_out = 0;
        end
`endif
        if (ld_out && !ld_iss) check("ld_latency", (cyc - ld_t) > 12, 0);
        if (tp_out && !tp_iss) check("tp_latency", (cyc - tp_t) > 12, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b_we, b_rd, b_tv;
        bus.ld_active = 0; bus.ld_wr = 0; bus.ld_addr = '0; bus.ld_din = '0;
        bus.tp_rd = 0; bus.tp_addr = '0; bus.mem_dout = '0; bus.mem_ready = 1;
        nx_ld_addr = '0; nx_tp_addr = '0; nx_ld_din = '0;
        td_exp = '0; be_data = '0; be_lat = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ld_wait", bus.ld_wait, 0);
        check("rst_cpu_stall", bus.cpu_stall, 0);
        check("rst_tp_valid", bus.tp_valid, 0);
        check("rst_tp_dout", bus.tp_dout, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_din", bus.mem_din, 0);
        reset = 0;

        // Loader write, back end low for 2 cycles
        be_lat = 2;
        b_we = we_cnt;
        nx_ld_addr = 25'h10; nx_ld_din = 8'hA5; nx_ld_wr = 1;
        repeat (10) cycle();
        check("t1_we_count", we_cnt - b_we, 1);

        // Tape read
        mem[25'h123] = 8'h5A;
        b_rd = rd_cnt; b_tv = tv_cnt;
        nx_tp_addr = 25'h123; nx_tp_rd = 1;
        repeat (10) cycle();
        check("t2_rd_count", rd_cnt - b_rd, 1);
        check("t2_tv_count", tv_cnt - b_tv, 1);
        check("t2_dout", bus.tp_dout, 8'h5A);

        // Same-cycle loader write and tape read
        b_we = we_cnt; b_rd = rd_cnt; b_tv = tv_cnt;
        nx_ld_addr = 25'h10; nx_ld_din = 8'h3C; nx_ld_wr = 1;
        nx_tp_addr = 25'h20; nx_tp_rd = 1;
        repeat (16) cycle();
        check("t3_we_count", we_cnt - b_we, 1);
        check("t3_rd_count", rd_cnt - b_rd, 1);
        check("t3_tv_count", tv_cnt - b_tv, 1);
        check("t3_order", last_we < last_rd, 1);

        // Tape read dropped during download
        b_rd = rd_cnt; b_tv = tv_cnt;
        nx_ld_active = 1; nx_tp_addr = 25'h30; nx_tp_rd = 1;
        repeat (8) cycle();
        nx_ld_active = 0;
        check("t4_rd_count", rd_cnt - b_rd, 0);
        check("t4_tv_count", tv_cnt - b_tv, 0);

        // Asynchronous reset while a read is stuck in WAIT
        hold_low = 1;
        b_tv = tv_cnt;
        nx_tp_addr = 25'h40; nx_tp_rd = 1;
        repeat (5) cycle();
        check("t5_pre_stall", bus.cpu_stall, 1);
        #2 reset = 1;
        #1;
        check("t5_ld_wait", bus.ld_wait, 0);
        check("t5_cpu_stall", bus.cpu_stall, 0);
        check("t5_tp_valid", bus.tp_valid, 0);
        check("t5_mem_rd", bus.mem_rd, 0);
        check("t5_mem_addr", bus.mem_addr, 0);
        check("t5_tp_dout", bus.tp_dout, 0);
        ld_out = 0; tp_out = 0; be_busy = 0; hold_low = 0; be_low = 0;
        tv_next = 0; td_exp = '0; bus.mem_ready = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        b_rd = rd_cnt;
        nx_tp_addr = 25'h123; nx_tp_rd = 1;
        repeat (10) cycle();
        check("t5_tv_count", tv_cnt - b_tv, 1);
        check("t5_rd_count", rd_cnt - b_rd, 1);
        check("t5_dout", bus.tp_dout, 8'h5A);

`ifdef RAM_ARB_WATCHDOG_EN
        // Watchdog abort of a tape read
        hold_low = 1;
        b_tv = tv_cnt;
        nx_tp_addr = 25'h55; nx_tp_rd = 1;
        repeat (24) cycle();
        check("t6_tv_count", tv_cnt - b_tv, 1);
        check("t6_dout", bus.tp_dout, 8'hFF);
        check("t6_err", err, 1);
`endif

        // Random traffic
        be_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            nx_ld_active = ($urandom_range(0, 5) == 0);
            if (!ld_out && $urandom_range(0, 2) == 0) begin
                nx_ld_wr   = 1;
                nx_ld_addr = AW'($urandom_range(0, 31));
                nx_ld_din  = 8'($urandom);
            end
            if (!tp_out && $urandom_range(0, 2) == 0) begin
                nx_tp_rd   = 1;
                nx_tp_addr = AW'($urandom_range(0, 31));
            end
            cycle();
        end
        nx_ld_active = 0;
        repeat (20) cycle();
        check("drain", {ld_out, tp_out}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single DDR byte port between two requesters: the ROM/TAP loader (writes during ioctl download) and the tape player (reads during playback).
- Latches one request per requester and issues it to the memory back end as a one-cycle strobe.
- Tracks completion by the rising edge of mem_ready.
- Drives the loader back-pressure (ld_wait) and a CPU-stall level, which the top uses to gate the 1 MHz CPU clock enable while tape data is outstanding.

Parameters:
- AW, 25, address width for both requesters and the back end.
- DW, 8, data width.
- TIMEOUT, 4096, cycles in WAIT before the watchdog aborts (used only with the optional feature).

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  asynchronous, active-high reset
- ld_active  in  1  loader download in progress (ioctl_download qualified by index)
- ld_wr  in  1  loader write strobe, one cycle
- ld_addr  in  AW  loader byte address
- ld_din  in  DW  loader write data
- ld_wait  out  1  loader must hold off further writes
- tp_rd  in  1  tape read strobe, one cycle
- tp_addr  in  AW  tape byte address
- tp_dout  out  DW  tape read data, valid with tp_valid
- tp_valid  out  1  one-cycle pulse: tp_dout updated
- cpu_stall  out  1  tape read pending or in flight
- mem_addr  out  AW  back-end address
- mem_din  out  DW  back-end write data
- mem_we  out  1  back-end write strobe, one cycle
- mem_rd  out  1  back-end read strobe, one cycle
- mem_dout  in  DW  back-end read data
- mem_ready  in  1  back end idle; a low-then-high transition marks completion

Behaviour:
- Reset values: all outputs 0; tp_dout=0; both pending flags clear; FSM in IDLE.
- Reset is asynchronous and can arrive mid-transaction. The in-flight access is abandoned with no tp_valid, and ld_wait drops immediately.
- Request capture:
  - ld_wr sets ld_pend and latches ld_addr/ld_din.
  - tp_rd sets tp_pend and latches tp_addr, but only when ld_active=0. A tp_rd with ld_active=1 is dropped.
  - A new strobe to an already-pending requester overwrites the latch (last wins); the pending flag stays set.
- ld_wait = ld_pend OR (owner==LD and state!=IDLE). It is asserted combinationally in the same cycle as ld_wr.
- cpu_stall = tp_pend OR (owner==TP and state!=IDLE). It is asserted in the same cycle as tp_rd.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE, with mem_ready=1 and any request pending:
    - Grant order: ld_pend first (fixed priority), else tp_pend.
    - Set owner, clear that requester's pending flag, load mem_addr/mem_din, go to ISSUE.
    - If mem_ready=0, stay in IDLE.
  - ISSUE: drive mem_we (owner LD) or mem_rd (owner TP) high for exactly one cycle, clear seen_low, go to WAIT.
  - WAIT:
    - Set seen_low when mem_ready=0.
    - Complete on mem_ready=1 with seen_low=1.
    - Owner TP: capture tp_dout<=mem_dout and pulse tp_valid in the same cycle.
    - Return to IDLE.
- Simultaneous ld_wr and tp_rd in IDLE (ld_active=0): both latched; LD is granted first and TP is served next.
- The earliest next grant is the cycle after WAIT→IDLE, so back-to-back accesses need at least 3 cycles plus memory latency.
- A strobe arriving in the completion cycle of the same requester is captured as a new pend and is not lost.
- mem_addr/mem_din hold their last value when idle.
- Address/data widths pass through unchanged; no arithmetic.

Optional Feature:
- Macro: RAM_ARB_WATCHDOG_EN.
- With the macro defined:
  - A 13-bit counter runs in WAIT.
  - On reaching TIMEOUT the FSM returns to IDLE. For owner TP it pulses tp_valid with tp_dout=8'hFF.
  - The sticky output err (1 bit, extra port) is set; it is cleared only by reset.
- Without the macro: no counter and no err port; WAIT can last indefinitely.

Decomposition:
- Package pet_ram_pkg: state enum {IDLE, ISSUE, WAIT}, owner enum {OWN_LD, OWN_TP}, localparam TP_TIMEOUT_DATA=8'hFF.
- One natural sub-module, ram_arb_req: a single-entry request latch (pend flag + addr/data registers, set/clear), instantiated twice.

Test Plan:
- Loader write, ld_wr addr=0x000010 din=0xA5, back end drops mem_ready 2 cycles then raises it -> mem_we pulse 1 cycle at 0x000010/0xA5; ld_wait high from the ld_wr cycle until the cycle after mem_ready rises.
- Tape read, tp_rd addr=0x000123, mem_dout=0x5A -> mem_rd one pulse; tp_valid one pulse with tp_dout=0x5A; cpu_stall high throughout and low after.
- Same-cycle ld_wr(0x10) and tp_rd(0x20) with ld_active=0 -> mem_we@0x10 first, then mem_rd@0x20; exactly one tp_valid.
- tp_rd while ld_active=1 -> no mem_rd, no tp_valid, cpu_stall stays 0.
- reset asserted in WAIT -> all outputs 0 asynchronously; the next tp_rd after reset is served normally.
- With RAM_ARB_WATCHDOG_EN, TIMEOUT=16, mem_ready held low -> tp_valid after 16 WAIT cycles with tp_dout=0xFF; err=1 and remains set.
